// File: rtl/operand_fetch.sv
// Operand fetch stage: reads one ROM word, widens it, pulses fim when done.
// Define OPERAND_SIGN_EXT_EN to sign-extend instead of zero-extend.
module operand_fetch #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 16,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  output logic [OUT_W-1:0]  data_out,
  output logic              fim,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    HOLD
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(ROM_LAT - 1);

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_rom_rd;
  logic [OUT_W-1:0]  r_data;
  logic              r_fim;
  logic              r_busy;

  state_t            w_nstate;
  logic [1:0]        w_cnt;
  logic [ADDR_W-1:0] w_rom_addr;
  logic              w_rom_rd;
  logic [OUT_W-1:0]  w_data;
  logic              w_fim;
  logic              w_busy;
  logic [OUT_W-1:0]  w_wide;

`ifdef OPERAND_SIGN_EXT_EN
  assign w_wide = {{(OUT_W-DATA_W){rom_data[DATA_W-1]}}, rom_data};
`else
  assign w_wide = {{(OUT_W-DATA_W){1'b0}}, rom_data};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rom_addr <= '0;
      r_rom_rd   <= 1'b0;
      r_data     <= '0;
      r_fim      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cnt      <= w_cnt;
      r_rom_addr <= w_rom_addr;
      r_rom_rd   <= w_rom_rd;
      r_data     <= w_data;
      r_fim      <= w_fim;
      r_busy     <= w_busy;
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_cnt      = r_cnt;
    w_rom_addr = r_rom_addr;
    w_rom_rd   = 1'b0;
    w_data     = r_data;
    w_fim      = 1'b0;
    w_busy     = r_busy;
    unique case (r_state)
      IDLE: begin
        if (en) begin
          w_rom_addr = addr;
          w_rom_rd   = 1'b1;
          w_busy     = 1'b1;
          w_cnt      = LAT_M1;
          w_nstate   = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 2'd0) w_nstate = CAPTURE;
        else               w_cnt    = r_cnt - 2'd1;
      end
      CAPTURE: begin
        w_data   = w_wide;
        w_fim    = 1'b1;
        w_nstate = HOLD;
      end
      HOLD: begin
        // Parked until the controller drops en, so one request = one fim.
        w_busy = 1'b0;
        if (!en) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  assign rom_addr = r_rom_addr;
  assign rom_rd   = r_rom_rd;
  assign data_out = r_data;
  assign fim      = r_fim;
  assign busy     = r_busy;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: ROM_LAT=1 and ROM_LAT=3 instances on shared stimulus,
// checked every cycle against a timestamp model plus literal expectations.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [8:0]  addr = '0;

  logic [8:0]  ra1, ra3;
  logic        rd1, rd3;
  logic [7:0]  rdat1, rdat3;
  logic [15:0] d1, d3;
  logic        f1, f3, b1, b3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  operand_fetch #(.ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .addr(addr),
    .rom_addr(ra1), .rom_rd(rd1), .rom_data(rdat1),
    .data_out(d1), .fim(f1), .busy(b1)
  );

  operand_fetch #(.ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .addr(addr),
    .rom_addr(ra3), .rom_rd(rd3), .rom_data(rdat3),
    .data_out(d3), .fim(f3), .busy(b3)
  );

  function automatic logic [7:0] mem(input logic [8:0] a);
    case (a)
      9'd0: mem = 8'h03;
      9'd1: mem = 8'hFF;
      9'd2: mem = 8'h07;
      9'd3: mem = 8'h55;
      9'd4: mem = 8'h11;
      9'd5: mem = 8'h2A;
      9'd6: mem = 8'h66;
      9'd7: mem = 8'h80;
      default: mem = a[7:0];
    endcase
  endfunction

  function automatic logic [15:0] widen(input logic [7:0] v);
`ifdef OPERAND_SIGN_EXT_EN
    widen = {{8{v[7]}}, v};
`else
    widen = {8'h00, v};
`endif
  endfunction

  // ROM models: data valid only exactly ROM_LAT cycles after rom_rd
  logic       pr1 = 1'b0;
  logic [7:0] pd1 = '0;
  logic       pr3 [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] pd3 [3] = '{8'h0, 8'h0, 8'h0};

  always @(posedge clk) begin
    pr1 <= rd1;
    pd1 <= mem(ra1);
    pr3[0] <= rd3;
    pd3[0] <= mem(ra3);
    pr3[1] <= pr3[0];
    pd3[1] <= pd3[0];
    pr3[2] <= pr3[1];
    pd3[2] <= pd3[1];
  end

  assign rdat1 = pr1 ? pd1 : 8'hA5;
  assign rdat3 = pr3[2] ? pd3[2] : 8'hA5;

  // Model: fetch starts at edge s, completes at edge s+LAT+1
  int          cyc = 0;
  logic        started = 1'b0;
  int          lat [2] = '{1, 3};
  logic        m_act [2];
  logic        m_hold [2];
  int          m_s [2];
  logic [8:0]  m_addr [2];
  logic        m_rd [2];
  logic        m_fim [2];
  logic        m_busy [2];
  logic [15:0] m_data [2];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        started   = 1'b1;
        m_act[i]  = 1'b0;
        m_hold[i] = 1'b0;
        m_addr[i] = '0;
        m_rd[i]   = 1'b0;
        m_fim[i]  = 1'b0;
        m_busy[i] = 1'b0;
        m_data[i] = '0;
      end else if (m_hold[i]) begin
        m_fim[i]  = 1'b0;
        m_busy[i] = 1'b0;
        if (!en) m_hold[i] = 1'b0;
      end else if (m_act[i]) begin
        m_rd[i] = 1'b0;
        if (cyc == m_s[i] + lat[i] + 1) begin
          m_fim[i]  = 1'b1;
          m_data[i] = widen(mem(m_addr[i]));
          m_act[i]  = 1'b0;
          m_hold[i] = 1'b1;
        end
      end else if (en) begin
        m_act[i]  = 1'b1;
        m_s[i]    = cyc;
        m_addr[i] = addr;
        m_rd[i]   = 1'b1;
        m_busy[i] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("L1.rom_addr", 32'(ra1), 32'(m_addr[0]));
      chk("L1.rom_rd", 32'(rd1), 32'(m_rd[0]));
      chk("L1.data_out", 32'(d1), 32'(m_data[0]));
      chk("L1.fim", 32'(f1), 32'(m_fim[0]));
      chk("L1.busy", 32'(b1), 32'(m_busy[0]));
      chk("L3.rom_addr", 32'(ra3), 32'(m_addr[1]));
      chk("L3.rom_rd", 32'(rd3), 32'(m_rd[1]));
      chk("L3.data_out", 32'(d3), 32'(m_data[1]));
      chk("L3.fim", 32'(f3), 32'(m_fim[1]));
      chk("L3.busy", 32'(b3), 32'(m_busy[1]));
    end
  end

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] exp_ff;
  logic [15:0] exp_80;
  int          pulses;

  initial begin
    exp_ff = widen(8'hFF);
    exp_80 = widen(8'h80);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.data_out", 32'(d1), 32'h0);
    chk("reset.fim_busy_rd", {29'd0, f1, b1, rd1}, 32'h0);

    // single fetch, en held high
    addr = 9'd5;
    en   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk("t1.rd_addr", {22'd0, rd1, ra1}, {22'd0, 1'b1, 9'd5});
      if (k == 2) chk("t1.no_fim_early", 32'(f1), 32'h0);
      if (k == 3) chk("t1.fim_data", {15'd0, f1, d1}, {15'd0, 1'b1, 16'h002A});
      if (k >= 4) chk("t1.no_second_fim", 32'(f1), 32'h0);
    end
    idle(4);

    // back-to-back fetches with one idle cycle
    addr   = 9'd0;
    en     = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (f1) pulses++;
      if (k == 3) chk("t2.first_data", 32'(d1), 32'h0003);
      if (k == 5) chk("t2.idle_gap_busy", 32'(b1), 32'h0);
      if (k == 6) chk("t2.second_rd", {22'd0, rd1, ra1}, {22'd0, 1'b1, 9'd2});
      if (k == 8) chk("t2.second_data", {15'd0, f1, d1}, {15'd0, 1'b1, 16'h0007});
      if (k == 4) en = 1'b0;
      if (k == 5) begin
        en   = 1'b1;
        addr = 9'd2;
      end
    end
    chk("t2.pulse_count", 32'(pulses), 32'd2);
    idle(8);

    // address changed mid-fetch
    addr = 9'd4;
    en   = 1'b1;
    @(negedge clk);
    addr = 9'd6;
    repeat (2) @(negedge clk);
    chk("t3.data", 32'(d1), 32'h0011);
    chk("t3.rom_addr", 32'(ra1), 32'd4);
    idle(8);

    // reset during WAIT
    addr = 9'd3;
    en   = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4.reset_outs", {5'd0, f1, b1, rd1, ra1, d1}, 32'h0);
    rst = 1'b0;
    idle(5);
    addr = 9'd6;
    en   = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4.refetch", {15'd0, f1, d1}, {15'd0, 1'b1, 16'h0066});
    idle(8);

    // ROM_LAT=3 timing and widening of 8'hFF
    addr = 9'd1;
    en   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) chk("t5.lat1_ff", 32'(d1), 32'(exp_ff));
      if (k == 4) chk("t5.lat3_no_fim", 32'(f3), 32'h0);
      if (k == 5) chk("t5.lat3_fim_data", {15'd0, f3, d3}, {15'd0, 1'b1, exp_ff});
    end
    idle(8);

    // en dropped during WAIT
    addr = 9'd7;
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6.fim_data", {15'd0, f1, d1}, {15'd0, 1'b1, exp_80});
    @(negedge clk);
    chk("t6.after_fim", {30'd0, f1, b1}, 32'h0);
    @(negedge clk);
    chk("t6.idle", {30'd0, rd1, b1}, 32'h0);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Front-end stage of the arithmetic datapath.
- On request, fetches one 8-bit operand word from the synchronous ROM and widens it to 16 bits.
- Presents the widened word on a held output register and reports completion with a one-cycle done pulse.
- One instance per operand register (A, B, C); the enable/done pair drives the controller's EnX/FimX handshake directly.

Parameters:
- ADDR_W, 9, ROM address width
- DATA_W, 8, ROM word width
- OUT_W, 16, widened output width (must be > DATA_W)
- ROM_LAT, 1, ROM read latency in clock cycles, legal range 1..4

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  fetch request, level; asserted by controller
- addr  in  ADDR_W  ROM address of operand, sampled when fetch starts
- rom_addr  out  ADDR_W  address driven to ROM
- rom_rd  out  1  ROM read strobe
- rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd
- data_out  out  OUT_W  widened operand, held until next capture or reset
- fim  out  1  one-cycle done pulse; data_out is valid in the same cycle
- busy  out  1  high from fetch start until fim cycle inclusive

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, rom_addr=0, rom_rd=0, data_out=0, fim=0, busy=0, latency counter=0.
- Reset has priority over every other event, including mid-fetch; the pending fetch is abandoned and produces no fim.
- States:
  - IDLE
    - If en=1: latch addr into rom_addr, rom_rd=1, busy=1, load counter with ROM_LAT-1, go to WAIT.
    - Otherwise stay; rom_rd=0.
  - WAIT
    - rom_rd=0.
    - If counter==0: go to CAPTURE; otherwise decrement counter.
  - CAPTURE
    - data_out <= widen(rom_data); fim=1 this cycle only; go to HOLD.
    - Data used is the rom_data value present exactly ROM_LAT cycles after the rom_rd cycle.
  - HOLD
    - fim=0, busy=0.
    - Stay until en=0, then go to IDLE.
    - No re-fetch while en stays high; this prevents repeated fim pulses when the controller has not yet dropped its enable.
- Latency:
  - en high at edge N gives rom_rd high in cycle N+1 and fim high in cycle N+1+ROM_LAT+1.
  - For ROM_LAT=1, fim occurs 3 cycles after en is first sampled.
- addr changes after fetch start are ignored until the next IDLE->WAIT transition.
- en dropping during WAIT or CAPTURE does not abort the fetch; fim still pulses, then HOLD sees en=0 and returns to IDLE on the next edge.
- en asserted in the same cycle the block leaves HOLD is sampled in IDLE on the following edge (minimum 1 idle cycle between fetches).
- Widening (default): zero-extension, upper OUT_W-DATA_W bits = 0. ROM word 8'hFF gives data_out 16'h00FF.
- data_out changes only in CAPTURE or on reset.
- fim and busy are registered outputs; there is no combinational path from en to any output.

Optional Feature:
- Macro: OPERAND_SIGN_EXT_EN
- Defined: widening is sign-extension from bit DATA_W-1.
  - 8'hFF gives 16'hFFFF.
  - 8'h7F gives 16'h007F.
- Not defined: zero-extension as above. All timing is identical in both builds.

Test Plan:
- Reset then single fetch, ROM_LAT=1, ROM[5]=8'h2A, en held high from cycle 0 with addr=5 -> rom_addr=5 with rom_rd=1 in cycle 1; fim=1 and data_out=16'h002A in cycle 3; fim=0 afterwards while en stays high (no second pulse).
- Back-to-back fetches: fetch addr 0 (ROM=8'h03), drop en one cycle after fim, re-assert with addr=2 (ROM=8'h07) -> two fim pulses; data_out 16'h0003 then 16'h0007; at least one IDLE cycle between them.
- Address changed mid-fetch: start fetch at addr 4 (ROM=8'h11), change addr to 6 in the WAIT cycle -> data_out=16'h0011, rom_addr stays 4.
- Reset mid-fetch: assert rst in the WAIT cycle -> no fim; all outputs 0 the next cycle; a new fetch afterwards completes normally.
- ROM_LAT=3, ROM[1]=8'hFF -> fim 5 cycles after en is sampled. Default build gives data_out=16'h00FF; build with OPERAND_SIGN_EXT_EN gives 16'hFFFF.
- en dropped during WAIT -> fim still pulses once; block returns to IDLE one cycle after fim; busy=0 from the cycle after fim.
